// File: rtl/overlay_scheduler.sv
// overlay_scheduler: sprite overlay sequencer for the pixel colorizer.
// The CPU writes a double-buffered sprite table that is committed at frame start.
// A 2-stage pipeline runs per-sprite hit test, lowest-index arbitration and
// icon ROM address generation, with video_on delayed to stay aligned.
// Optional: define OVERLAY_SCHEDULER_COLLISION_EN for a sticky collision flag.
module overlay_scheduler #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int COORD_W     = 10
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [COORD_W-1:0]                    pixel_row,
  input  logic [COORD_W-1:0]                    pixel_column,
  input  logic                                  video_on,
  input  logic                                  frame_start,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  input  logic [2:0]                            cfg_idx,
  input  logic [COORD_W-1:0]                    cfg_x,
  input  logic [COORD_W-1:0]                    cfg_y,
  input  logic                                  cfg_en,
  input  logic                                  cfg_commit,
  output logic                                  commit_pending,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  rom_addr,
  output logic                                  layer_hit,
  output logic [2:0]                            layer_sel,
  output logic                                  video_on_d
`ifdef OVERLAY_SCHEDULER_COLLISION_EN
  ,
  output logic                                  collision
`endif
);

  localparam int N      = NUM_SPRITES;
  localparam int COL_W  = $clog2(SPRITE_W);
  localparam int ROW_W  = $clog2(SPRITE_H);
  localparam int ADDR_W = $clog2(SPRITE_W*SPRITE_H);

  // Shadow (CPU-facing) and active (pipeline-facing) sprite tables
  logic [N-1:0][COORD_W-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic [N-1:0][COORD_W-1:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic [N-1:0]              sh_en_q, sh_en_d, act_en_q, act_en_d;
  logic                      pend_q, pend_d;
  logic                      cfg_accept;

  // Stage 1 registers
  logic [N-1:0][COORD_W:0]   dcol, drow;
  logic [N-1:0]              hit_s1_q, hit_s1_d;
  logic [N-1:0][COL_W-1:0]   coff_s1_q, coff_s1_d;
  logic [N-1:0][ROW_W-1:0]   roff_s1_q, roff_s1_d;
  logic                      vid_s1_q, vid_s1_d;

  // Stage 2 registers
  logic                      hit_q, hit_d;
  logic [2:0]                sel_q, sel_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      vid_o_q, vid_o_d;

  // A commit and a write never share a cycle: the write is stalled instead
  assign cfg_ready      = !(frame_start && pend_q);
  assign cfg_accept     = cfg_valid && cfg_ready;
  assign commit_pending = pend_q;
  assign rom_addr       = addr_q;
  assign layer_hit      = hit_q;
  assign layer_sel      = sel_q;
  assign video_on_d     = vid_o_q;

  // Table update: CPU writes land in shadow, frame_start copies shadow to active
  always_comb begin
    sh_x_d   = sh_x_q;
    sh_y_d   = sh_y_q;
    sh_en_d  = sh_en_q;
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    act_en_d = act_en_q;
    pend_d   = pend_q;
    if (frame_start && pend_q) begin
      act_x_d  = sh_x_q;
      act_y_d  = sh_y_q;
      act_en_d = sh_en_q;
      pend_d   = 1'b0;
    end
    if (cfg_accept) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (cfg_idx == 3'(i)) begin
          sh_x_d[i]  = cfg_x;
          sh_y_d[i]  = cfg_y;
          sh_en_d[i] = cfg_en;
        end
      end
      if (cfg_commit) pend_d = 1'b1;
    end
  end

  // Stage 1: per-sprite unsigned range check; a negative difference is a huge
  // unsigned value and therefore fails the upper-bound compare (no wrap-around)
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      dcol[i]      = {1'b0, pixel_column} - {1'b0, act_x_q[i]};
      drow[i]      = {1'b0, pixel_row} - {1'b0, act_y_q[i]};
      hit_s1_d[i]  = video_on && act_en_q[i] &&
                     (dcol[i] < (COORD_W+1)'(SPRITE_W)) &&
                     (drow[i] < (COORD_W+1)'(SPRITE_H));
      coff_s1_d[i] = dcol[i][COL_W-1:0];
      roff_s1_d[i] = drow[i][ROW_W-1:0];
    end
    vid_s1_d = video_on;
  end

  // Stage 2: lowest-index hit wins and selects the ROM address
  always_comb begin
    hit_d  = 1'b0;
    sel_d  = '0;
    addr_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (hit_s1_q[i] && !hit_d) begin
        hit_d  = 1'b1;
        sel_d  = 3'(i);
        addr_d = ADDR_W'({roff_s1_q[i], coff_s1_q[i]});
      end
    end
    vid_o_d = vid_s1_q;
  end

`ifdef OVERLAY_SCHEDULER_COLLISION_EN
  logic coll_q, coll_d;
  logic multi_hit;

  // Sticky collision: two or more stage-1 hits; detection beats frame_start clear
  always_comb begin
    multi_hit = |(hit_s1_q & (hit_s1_q - N'(1)));
    coll_d    = coll_q;
    if (multi_hit)        coll_d = 1'b1;
    else if (frame_start) coll_d = 1'b0;
  end

  // Collision flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) coll_q <= 1'b0;
    else          coll_q <= coll_d;
  end

  assign collision = coll_q;
`endif

  // All table and pipeline state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_x_q    <= '0;
      sh_y_q    <= '0;
      sh_en_q   <= '0;
      act_x_q   <= '0;
      act_y_q   <= '0;
      act_en_q  <= '0;
      pend_q    <= 1'b0;
      hit_s1_q  <= '0;
      coff_s1_q <= '0;
      roff_s1_q <= '0;
      vid_s1_q  <= 1'b0;
      hit_q     <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      vid_o_q   <= 1'b0;
    end else begin
      sh_x_q    <= sh_x_d;
      sh_y_q    <= sh_y_d;
      sh_en_q   <= sh_en_d;
      act_x_q   <= act_x_d;
      act_y_q   <= act_y_d;
      act_en_q  <= act_en_d;
      pend_q    <= pend_d;
      hit_s1_q  <= hit_s1_d;
      coff_s1_q <= coff_s1_d;
      roff_s1_q <= roff_s1_d;
      vid_s1_q  <= vid_s1_d;
      hit_q     <= hit_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      vid_o_q   <= vid_o_d;
    end
  end

endmodule

// File: tb/tb_overlay_scheduler.sv
// Directed testbench for overlay_scheduler (default parameters: 4 sprites, 16x16, 10-bit coords).
module tb_overlay_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] pixel_row = '0, pixel_column = '0;
  logic       video_on = 1'b0, frame_start = 1'b0;
  logic       cfg_valid = 1'b0, cfg_ready;
  logic [2:0] cfg_idx = '0;
  logic [9:0] cfg_x = '0, cfg_y = '0;
  logic       cfg_en = 1'b0, cfg_commit = 1'b0;
  logic       commit_pending;
  logic [7:0] rom_addr;
  logic       layer_hit;
  logic [2:0] layer_sel;
  logic       video_on_d;
`ifdef OVERLAY_SCHEDULER_COLLISION_EN
  logic       collision;
`endif

  int errors = 0;
  int checks = 0;

  overlay_scheduler #(.NUM_SPRITES(4), .SPRITE_W(16), .SPRITE_H(16), .COORD_W(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .pixel_row(pixel_row), .pixel_column(pixel_column),
    .video_on(video_on), .frame_start(frame_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en), .cfg_commit(cfg_commit),
    .commit_pending(commit_pending), .rom_addr(rom_addr),
    .layer_hit(layer_hit), .layer_sel(layer_sel), .video_on_d(video_on_d)
`ifdef OVERLAY_SCHEDULER_COLLISION_EN
    , .collision(collision)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [9:0] r, input logic [9:0] c, input logic v);
    pixel_row = r;
    pixel_column = c;
    video_on = v;
  endtask

  // Hold a visible pixel long enough to reach the outputs
  task automatic scan(input logic [9:0] r, input logic [9:0] c);
    set_pix(r, c, 1'b1);
    tick();
    tick();
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                           input logic en, input logic cm);
    cfg_valid = 1'b1; cfg_idx = idx; cfg_x = x; cfg_y = y; cfg_en = en; cfg_commit = cm;
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic pulse_frame;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    set_pix(10'd53, 10'd107, 1'b1);
    tick(); tick(); tick();
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %0b want 0", layer_hit); end
    checks++; if (layer_sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", layer_sel); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", rom_addr); end
    checks++; if (video_on_d !== 1'b0) begin errors++; $display("FAIL reset_vid: got %0b want 0", video_on_d); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", cfg_ready); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_pend: got %0b want 0", commit_pending); end
    reset_n = 1'b1;
    set_pix(10'd0, 10'd0, 1'b0);
  endtask

  task automatic test_blank_scan;
    logic [7:0] pat;
    pat = 8'b1011_0010;
    for (int j = 0; j < 8; j++) begin
      set_pix(10'd53, 10'(100 + j), pat[j]);
      tick();
      if (j >= 1) begin
        checks++; if (video_on_d !== pat[j-1]) begin errors++; $display("FAIL blank_vid[%0d]: got %0b want %0b", j, video_on_d, pat[j-1]); end
        checks++; if (layer_hit !== 1'b0 || rom_addr !== 8'h00) begin errors++; $display("FAIL blank_hit[%0d]: got hit=%0b addr=%h want 0/00", j, layer_hit, rom_addr); end
      end
    end
  endtask

  task automatic test_single_sprite;
    cfg_write(3'd0, 10'd100, 10'd50, 1'b1, 1'b1);
    checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL single_pend_set: got %0b want 1", commit_pending); end
    scan(10'd53, 10'd107);
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL single_precommit: got %0b want 0", layer_hit); end
    pulse_frame();
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL single_pend_clr: got %0b want 0", commit_pending); end
    scan(10'd53, 10'd107);
    checks++; if (layer_hit !== 1'b1 || layer_sel !== 3'd0 || rom_addr !== 8'h37) begin errors++; $display("FAIL single_hit: got hit=%0b sel=%0d addr=%h want 1/0/37", layer_hit, layer_sel, rom_addr); end
    set_pix(10'd53, 10'd107, 1'b0);
    tick(); tick();
    checks++; if (layer_hit !== 1'b0 || rom_addr !== 8'h00) begin errors++; $display("FAIL single_vidoff: got hit=%0b addr=%h want 0/00", layer_hit, rom_addr); end
    scan(10'd53, 10'd99);
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL single_left_of_x: got %0b want 0", layer_hit); end
  endtask

  task automatic test_priority;
    cfg_write(3'd1, 10'd200, 10'd200, 1'b1, 1'b0);
    cfg_write(3'd2, 10'd200, 10'd200, 1'b1, 1'b1);
    pulse_frame();
    scan(10'd205, 10'd205);
    checks++; if (layer_hit !== 1'b1 || layer_sel !== 3'd1 || rom_addr !== 8'h55) begin errors++; $display("FAIL prio_hit: got hit=%0b sel=%0d addr=%h want 1/1/55", layer_hit, layer_sel, rom_addr); end
`ifdef OVERLAY_SCHEDULER_COLLISION_EN
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_set: got %0b want 1", collision); end
    scan(10'd0, 10'd0);
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL coll_sticky: got %0b want 1", collision); end
    pulse_frame();
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL coll_clear: got %0b want 0", collision); end
`else
    scan(10'd0, 10'd0);
`endif
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL prio_miss: got %0b want 0", layer_hit); end
  endtask

  task automatic test_mid_frame_commit;
    cfg_write(3'd0, 10'd300, 10'd50, 1'b1, 1'b1);
    cfg_write(3'd3, 10'd400, 10'd100, 1'b1, 1'b0);
    scan(10'd53, 10'd107);
    checks++; if (layer_hit !== 1'b1 || layer_sel !== 3'd0 || rom_addr !== 8'h37) begin errors++; $display("FAIL mid_old_slot0: got hit=%0b sel=%0d addr=%h want 1/0/37", layer_hit, layer_sel, rom_addr); end
    scan(10'd102, 10'd401);
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL mid_slot3_early: got %0b want 0", layer_hit); end
    pulse_frame();
    scan(10'd53, 10'd307);
    checks++; if (layer_hit !== 1'b1 || layer_sel !== 3'd0 || rom_addr !== 8'h37) begin errors++; $display("FAIL mid_new_slot0: got hit=%0b sel=%0d addr=%h want 1/0/37", layer_hit, layer_sel, rom_addr); end
    scan(10'd102, 10'd401);
    checks++; if (layer_hit !== 1'b1 || layer_sel !== 3'd3 || rom_addr !== 8'h21) begin errors++; $display("FAIL mid_slot3: got hit=%0b sel=%0d addr=%h want 1/3/21", layer_hit, layer_sel, rom_addr); end
    scan(10'd53, 10'd107);
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL mid_old_gone: got %0b want 0", layer_hit); end
  endtask

  task automatic test_back_to_back;
    cfg_write(3'd3, 10'd630, 10'd0, 1'b1, 1'b1);
    frame_start = 1'b1;
    cfg_valid = 1'b1; cfg_idx = 3'd1; cfg_x = 10'd200; cfg_y = 10'd200; cfg_en = 1'b0; cfg_commit = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_low: got %0b want 0", cfg_ready); end
    tick();
    frame_start = 1'b0;
    #1;
    checks++; if (cfg_ready !== 1'b1 || commit_pending !== 1'b0) begin errors++; $display("FAIL stall_after: got ready=%0b pend=%0b want 1/0", cfg_ready, commit_pending); end
    tick();
    cfg_valid = 1'b0;
    scan(10'd205, 10'd205);
    checks++; if (layer_hit !== 1'b1 || layer_sel !== 3'd1) begin errors++; $display("FAIL stall_shadow_only: got hit=%0b sel=%0d want 1/1", layer_hit, layer_sel); end
    pulse_frame();
    scan(10'd205, 10'd205);
    checks++; if (layer_hit !== 1'b1 || layer_sel !== 3'd1) begin errors++; $display("FAIL frame_no_pend: got hit=%0b sel=%0d want 1/1", layer_hit, layer_sel); end
    cfg_write(3'd2, 10'd200, 10'd200, 1'b0, 1'b1);
    pulse_frame();
    scan(10'd205, 10'd205);
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL stall_landed: got %0b want 0", layer_hit); end
  endtask

  task automatic test_edges;
    scan(10'd5, 10'd639);
    checks++; if (layer_hit !== 1'b1 || layer_sel !== 3'd3 || rom_addr !== 8'h59) begin errors++; $display("FAIL edge_right: got hit=%0b sel=%0d addr=%h want 1/3/59", layer_hit, layer_sel, rom_addr); end
    scan(10'd5, 10'd0);
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL edge_no_wrap: got %0b want 0", layer_hit); end
    scan(10'd5, 10'd630);
    checks++; if (rom_addr !== 8'h50 || layer_hit !== 1'b1) begin errors++; $display("FAIL edge_x0: got hit=%0b addr=%h want 1/50", layer_hit, rom_addr); end
    scan(10'd5, 10'd629);
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL edge_x_minus1: got %0b want 0", layer_hit); end
    scan(10'd65, 10'd315);
    checks++; if (layer_hit !== 1'b1 || rom_addr !== 8'hFF) begin errors++; $display("FAIL edge_corner: got hit=%0b addr=%h want 1/ff", layer_hit, rom_addr); end
    scan(10'd66, 10'd315);
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL edge_below: got %0b want 0", layer_hit); end
    scan(10'd50, 10'd316);
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL edge_right_of: got %0b want 0", layer_hit); end
  endtask

  task automatic test_out_of_range;
    cfg_write(3'd5, 10'd0, 10'd0, 1'b1, 1'b1);
    checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL oor_pend: got %0b want 1", commit_pending); end
    pulse_frame();
    scan(10'd3, 10'd3);
    checks++; if (layer_hit !== 1'b0) begin errors++; $display("FAIL oor_no_change: got %0b want 0", layer_hit); end
  endtask

  task automatic test_reset_midframe;
    scan(10'd65, 10'd315);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (layer_hit !== 1'b0 || rom_addr !== 8'h00 || video_on_d !== 1'b0) begin errors++; $display("FAIL rst_mid_async: got hit=%0b addr=%h vid=%0b want 0/00/0", layer_hit, rom_addr, video_on_d); end
    tick();
    reset_n = 1'b1;
    scan(10'd65, 10'd315);
    checks++; if (layer_hit !== 1'b0 || commit_pending !== 1'b0) begin errors++; $display("FAIL rst_mid_cleared: got hit=%0b pend=%0b want 0/0", layer_hit, commit_pending); end
  endtask

  initial begin
    test_reset();
    test_blank_scan();
    test_single_sprite();
    test_priority();
    test_mid_frame_commit();
    test_back_to_back();
    test_edges();
    test_out_of_range();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
